// File: rtl/block_packer.sv
// rtl/block_packer.sv - byte-to-block packer with PKCS#7-style final-block padding
// Bytes fill a block MSB-first; the closing byte of a message pads the remaining lanes.
module block_packer #(
   parameter int BLOCK_WIDTH     = 32,
   parameter int PAD_FULL_BLOCK  = 1,
   parameter int MSG_COUNT_WIDTH = 16
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic [7:0]                 i_byte_in,
   input  logic                       i_byte_in_valid,
   input  logic                       i_byte_in_last,
   output logic                       o_byte_in_ready,
   output logic [BLOCK_WIDTH-1:0]     o_data_out,
   output logic                       o_data_out_valid,
   output logic                       o_data_out_last,
   input  logic                       i_data_out_ready,
   output logic                       o_busy,
   output logic [MSG_COUNT_WIDTH-1:0] o_msg_count
);
   localparam int NB = BLOCK_WIDTH / 8;
   localparam int IW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);
   localparam logic [7:0]    NB_BYTE  = 8'(NB);

   typedef enum logic {FILL, PAD} state_t;

   state_t                     r_state;
   logic [IW-1:0]              r_idx;
   logic [BLOCK_WIDTH-1:0]     r_acc;
   logic [BLOCK_WIDTH-1:0]     r_data;
   logic                       r_valid;
   logic                       r_last;
   logic [MSG_COUNT_WIDTH-1:0] r_count;

   state_t                     w_state_nxt;
   logic [IW-1:0]              w_idx_nxt;
   logic [BLOCK_WIDTH-1:0]     w_acc_nxt;
   logic [BLOCK_WIDTH-1:0]     w_data_nxt;
   logic                       w_valid_nxt;
   logic                       w_last_nxt;
   logic [MSG_COUNT_WIDTH-1:0] w_count_nxt;

   logic                       w_oreg_free;
   logic                       w_idx_full;
   logic                       w_closing;
   logic                       w_ready;
   logic [7:0]                 w_pad_val;
   logic [BLOCK_WIDTH-1:0]     w_block;
   logic [BLOCK_WIDTH-1:0]     w_acc_ins;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= FILL;
         r_idx   <= '0;
         r_acc   <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_acc   <= w_acc_nxt;
         r_data  <= w_data_nxt;
         r_valid <= w_valid_nxt;
         r_last  <= w_last_nxt;
         r_count <= w_count_nxt;
      end
   end

   always_comb begin
      w_oreg_free = !r_valid || i_data_out_ready;
      w_idx_full  = (r_idx == LAST_IDX);
      w_closing   = w_idx_full || i_byte_in_last;
      w_pad_val   = NB_BYTE - 8'd1 - 8'(r_idx);

      // Lanes before idx come from the accumulator, idx takes the new byte, the rest get pad.
      w_block   = '0;
      w_acc_ins = r_acc;
      for (int k = 0; k < NB; k++) begin
         if (k < int'(r_idx)) begin
            w_block[BLOCK_WIDTH-1-8*k -: 8] = r_acc[BLOCK_WIDTH-1-8*k -: 8];
         end else if (k == int'(r_idx)) begin
            w_block[BLOCK_WIDTH-1-8*k -: 8]   = i_byte_in;
            w_acc_ins[BLOCK_WIDTH-1-8*k -: 8] = i_byte_in;
         end else begin
            w_block[BLOCK_WIDTH-1-8*k -: 8] = w_pad_val;
         end
      end

      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_acc_nxt   = r_acc;
      w_data_nxt  = r_data;
      w_valid_nxt = r_valid;
      w_last_nxt  = r_last;
      w_count_nxt = r_count;
      w_ready     = 1'b0;

      if (r_valid && i_data_out_ready) begin
         w_valid_nxt = 1'b0;
         if (r_last) begin
            w_count_nxt = r_count + MSG_COUNT_WIDTH'(1);
         end
      end

      case (r_state)
         FILL: begin
            w_ready = !(w_closing && !w_oreg_free);
            if (i_byte_in_valid && w_ready) begin
               if (!w_closing) begin
                  w_acc_nxt = w_acc_ins;
                  w_idx_nxt = r_idx + IW'(1);
               end else begin
                  w_data_nxt  = w_block;
                  w_valid_nxt = 1'b1;
                  w_idx_nxt   = '0;
                  w_acc_nxt   = '0;
                  if (i_byte_in_last && w_idx_full && (PAD_FULL_BLOCK != 0)) begin
                     w_last_nxt  = 1'b0;
                     w_state_nxt = PAD;
                  end else begin
                     w_last_nxt = i_byte_in_last;
                  end
               end
            end
         end
         PAD: begin
            if (w_oreg_free) begin
               w_data_nxt  = {NB{NB_BYTE}};
               w_valid_nxt = 1'b1;
               w_last_nxt  = 1'b1;
               w_state_nxt = FILL;
            end
         end
         default: w_state_nxt = FILL;
      endcase
   end

   assign o_byte_in_ready  = w_ready;
   assign o_data_out       = r_data;
   assign o_data_out_valid = r_valid;
   assign o_data_out_last  = r_last;
   assign o_msg_count      = r_count;
   assign o_busy           = (r_idx != '0) || (r_state == PAD) || r_valid;
endmodule

// File: tb/tb_block_packer.sv
// tb/tb_block_packer.sv - directed self-checking bench for block_packer
module tb_block_packer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  byte_in = 8'h00;
   logic        byte_valid = 1'b0;
   logic        byte_valid_0 = 1'b0;
   logic        byte_last = 1'b0;
   logic        byte_ready, byte_ready_0;
   logic [31:0] dout, dout_0;
   logic        dout_valid, dout_valid_0;
   logic        dout_last, dout_last_0;
   logic        dout_ready = 1'b1;
   logic        dout_ready_0 = 1'b1;
   logic        busy, busy_0;
   logic [15:0] msg_count, msg_count_0;

   int checks = 0;
   int errors = 0;
   logic [32:0] q[$];

   block_packer #(.BLOCK_WIDTH(32), .PAD_FULL_BLOCK(1), .MSG_COUNT_WIDTH(16)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_byte_in(byte_in), .i_byte_in_valid(byte_valid), .i_byte_in_last(byte_last),
      .o_byte_in_ready(byte_ready),
      .o_data_out(dout), .o_data_out_valid(dout_valid), .o_data_out_last(dout_last),
      .i_data_out_ready(dout_ready), .o_busy(busy), .o_msg_count(msg_count)
   );

   block_packer #(.BLOCK_WIDTH(32), .PAD_FULL_BLOCK(0), .MSG_COUNT_WIDTH(16)) dut0 (
      .i_clk(clk), .i_rst(rst),
      .i_byte_in(byte_in), .i_byte_in_valid(byte_valid_0), .i_byte_in_last(byte_last),
      .o_byte_in_ready(byte_ready_0),
      .o_data_out(dout_0), .o_data_out_valid(dout_valid_0), .o_data_out_last(dout_last_0),
      .i_data_out_ready(dout_ready_0), .o_busy(busy_0), .o_msg_count(msg_count_0)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst && dout_valid && dout_ready) q.push_back({dout_last, dout});
   end

   task automatic send_byte(input int which, input logic [7:0] b, input logic l, output bit waited);
      int n;
      n = 0;
      waited = 1'b0;
      byte_in = b;
      byte_last = l;
      if (which == 0) byte_valid = 1'b1; else byte_valid_0 = 1'b1;
      @(negedge clk);
      while (((which == 0) ? !byte_ready : !byte_ready_0) && n < 100) begin
         waited = 1'b1;
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++; errors++;
         $display("FAIL send_timeout: byte %02h never accepted, ready=0 required 1", b);
      end
      @(posedge clk); #1;
      byte_valid = 1'b0;
      byte_valid_0 = 1'b0;
      byte_last = 1'b0;
   endtask

   task automatic apply_reset;
      rst = 1'b1;
      byte_valid = 1'b0; byte_valid_0 = 1'b0; byte_last = 1'b0; byte_in = 8'h00;
      dout_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      q.delete();
   endtask

   task automatic test_reset;
      rst = 1'b1;
      @(negedge clk);
      checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", dout_valid); end
      checks++; if (dout !== 32'h0) begin errors++; $display("FAIL rst_data: got %h expected 00000000", dout); end
      checks++; if (dout_last !== 1'b0) begin errors++; $display("FAIL rst_last: got %b expected 0", dout_last); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
      checks++; if (msg_count !== 16'h0) begin errors++; $display("FAIL rst_count: got %h expected 0000", msg_count); end
      checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", byte_ready); end
      apply_reset();
   endtask

   task automatic test_basic;
      bit w;
      apply_reset();
      send_byte(0, 8'h11, 1'b0, w);
      send_byte(0, 8'h22, 1'b0, w);
      send_byte(0, 8'h33, 1'b0, w);
      send_byte(0, 8'h44, 1'b0, w);
      send_byte(0, 8'h55, 1'b1, w);
      repeat (3) @(negedge clk);
      checks++; if (q.size() !== 2) begin errors++; $display("FAIL basic_nblk: got %0d expected 2", q.size()); end
      checks++; if (q[0] !== {1'b0, 32'h11223344}) begin errors++; $display("FAIL basic_blk0: got %h expected 011223344", q[0]); end
      checks++; if (q[1] !== {1'b1, 32'h55030303}) begin errors++; $display("FAIL basic_blk1: got %h expected 155030303", q[1]); end
      checks++; if (msg_count !== 16'd1) begin errors++; $display("FAIL basic_count: got %0d expected 1", msg_count); end
   endtask

   task automatic test_pad_full;
      bit w;
      apply_reset();
      send_byte(0, 8'hAA, 1'b0, w);
      send_byte(0, 8'hBB, 1'b0, w);
      send_byte(0, 8'hCC, 1'b0, w);
      send_byte(0, 8'hDD, 1'b1, w);
      @(negedge clk);
      checks++; if ({dout_valid, dout_last, dout} !== {2'b10, 32'hAABBCCDD}) begin errors++; $display("FAIL pad_data_blk: got v=%b l=%b %h expected v=1 l=0 aabbccdd", dout_valid, dout_last, dout); end
      checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL pad_ready: got %b expected 0", byte_ready); end
      @(negedge clk);
      checks++; if ({dout_valid, dout_last, dout} !== {2'b11, 32'h04040404}) begin errors++; $display("FAIL pad_blk: got v=%b l=%b %h expected v=1 l=1 04040404", dout_valid, dout_last, dout); end
      checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL pad_ready_back: got %b expected 1", byte_ready); end
      @(negedge clk);
      checks++; if (msg_count !== 16'd1) begin errors++; $display("FAIL pad_count: got %0d expected 1", msg_count); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pad_busy: got %b expected 0", busy); end
      @(posedge clk); #1;
      send_byte(1, 8'hAA, 1'b0, w);
      send_byte(1, 8'hBB, 1'b0, w);
      send_byte(1, 8'hCC, 1'b0, w);
      send_byte(1, 8'hDD, 1'b1, w);
      @(negedge clk);
      checks++; if ({dout_valid_0, dout_last_0, dout_0} !== {2'b11, 32'hAABBCCDD}) begin errors++; $display("FAIL nopad_blk: got v=%b l=%b %h expected v=1 l=1 aabbccdd", dout_valid_0, dout_last_0, dout_0); end
      @(negedge clk);
      checks++; if (dout_valid_0 !== 1'b0) begin errors++; $display("FAIL nopad_extra: got valid %b expected 0", dout_valid_0); end
      checks++; if (msg_count_0 !== 16'd1) begin errors++; $display("FAIL nopad_count: got %0d expected 1", msg_count_0); end
   endtask

   task automatic test_stall;
      int first_wait;
      int seen;
      int stable_bad;
      apply_reset();
      dout_ready = 1'b0;
      first_wait = -1;
      seen = 0;
      stable_bad = 0;
      fork
         begin
            bit w;
            for (int i = 0; i < 12; i++) begin
               send_byte(0, 8'(i), (i == 11), w);
               if (w && first_wait < 0) first_wait = i;
            end
         end
         begin
            repeat (10) begin
               @(negedge clk);
               if (dout_valid) begin
                  seen++;
                  if (dout !== 32'h00010203) stable_bad++;
               end
            end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b expected 1", busy); end
            @(posedge clk); #1 dout_ready = 1'b1;
         end
      join
      repeat (6) @(negedge clk);
      checks++; if (first_wait !== 7) begin errors++; $display("FAIL stall_ready_drop: got byte %0d expected 7", first_wait); end
      checks++; if (seen !== 6 || stable_bad !== 0) begin errors++; $display("FAIL stall_hold: got %0d valid cycles %0d changed expected 6 and 0", seen, stable_bad); end
      checks++; if (q.size() !== 4) begin errors++; $display("FAIL stall_nblk: got %0d expected 4", q.size()); end
      checks++; if (q[0] !== {1'b0, 32'h00010203}) begin errors++; $display("FAIL stall_blk0: got %h expected 000010203", q[0]); end
      checks++; if (q[1] !== {1'b0, 32'h04050607}) begin errors++; $display("FAIL stall_blk1: got %h expected 004050607", q[1]); end
      checks++; if (q[2] !== {1'b0, 32'h08090A0B}) begin errors++; $display("FAIL stall_blk2: got %h expected 008090a0b", q[2]); end
      checks++; if (q[3] !== {1'b1, 32'h04040404}) begin errors++; $display("FAIL stall_blk3: got %h expected 104040404", q[3]); end
      checks++; if (msg_count !== 16'd1) begin errors++; $display("FAIL stall_count: got %0d expected 1", msg_count); end
   endtask

   task automatic test_single;
      bit w;
      apply_reset();
      send_byte(0, 8'h7E, 1'b1, w);
      @(negedge clk);
      checks++; if ({dout_valid, dout_last, dout} !== {2'b11, 32'h7E030303}) begin errors++; $display("FAIL single_blk: got v=%b l=%b %h expected v=1 l=1 7e030303", dout_valid, dout_last, dout); end
      @(posedge clk); #1;
      send_byte(0, 8'h01, 1'b0, w);
      byte_last = 1'b1;
      @(posedge clk); #1;
      byte_last = 1'b0;
      send_byte(0, 8'h02, 1'b1, w);
      @(negedge clk);
      checks++; if ({dout_valid, dout_last, dout} !== {2'b11, 32'h01020202}) begin errors++; $display("FAIL two_byte_blk: got v=%b l=%b %h expected v=1 l=1 01020202", dout_valid, dout_last, dout); end
      @(negedge clk);
      checks++; if (msg_count !== 16'd2) begin errors++; $display("FAIL single_count: got %0d expected 2", msg_count); end
      checks++; if (q.size() !== 2) begin errors++; $display("FAIL single_nblk: got %0d expected 2", q.size()); end
   endtask

   task automatic test_async_reset;
      bit w;
      apply_reset();
      send_byte(0, 8'h55, 1'b1, w);
      repeat (2) @(posedge clk);
      #1;
      checks++; if (msg_count !== 16'd1) begin errors++; $display("FAIL ar_pre_count: got %0d expected 1", msg_count); end
      dout_ready = 1'b0;
      send_byte(0, 8'hA1, 1'b0, w);
      send_byte(0, 8'hA2, 1'b0, w);
      send_byte(0, 8'hA3, 1'b0, w);
      send_byte(0, 8'hA4, 1'b0, w);
      send_byte(0, 8'hB1, 1'b0, w);
      send_byte(0, 8'hB2, 1'b0, w);
      @(negedge clk);
      checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid: got %b expected 1", dout_valid); end
      #2 rst = 1'b1;
      #1;
      checks++; if ({dout_valid, busy} !== 2'b00) begin errors++; $display("FAIL ar_async: got valid=%b busy=%b expected 0 0", dout_valid, busy); end
      checks++; if (msg_count !== 16'd0) begin errors++; $display("FAIL ar_count: got %0d expected 0", msg_count); end
      @(posedge clk); #1;
      rst = 1'b0;
      dout_ready = 1'b1;
      q.delete();
      send_byte(0, 8'h10, 1'b0, w);
      send_byte(0, 8'h20, 1'b0, w);
      send_byte(0, 8'h30, 1'b0, w);
      send_byte(0, 8'h40, 1'b1, w);
      repeat (4) @(negedge clk);
      checks++; if (q.size() !== 2) begin errors++; $display("FAIL ar_nblk: got %0d expected 2", q.size()); end
      checks++; if (q[0] !== {1'b0, 32'h10203040}) begin errors++; $display("FAIL ar_blk0: got %h expected 010203040", q[0]); end
      checks++; if (q[1] !== {1'b1, 32'h04040404}) begin errors++; $display("FAIL ar_blk1: got %h expected 104040404", q[1]); end
   endtask

   task automatic test_wrap;
      bit w;
      int not_ready;
      apply_reset();
      not_ready = 0;
      byte_in = 8'h5A;
      byte_last = 1'b1;
      byte_valid = 1'b1;
      for (int i = 0; i < 65535; i++) begin
         @(negedge clk);
         if (!byte_ready) not_ready++;
         @(posedge clk);
      end
      #1;
      byte_valid = 1'b0;
      byte_last = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (not_ready !== 0) begin errors++; $display("FAIL wrap_throughput: got %0d stalls expected 0", not_ready); end
      checks++; if (msg_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_count_max: got %h expected ffff", msg_count); end
      @(posedge clk); #1;
      send_byte(0, 8'h5A, 1'b1, w);
      repeat (2) @(negedge clk);
      checks++; if (msg_count !== 16'h0000) begin errors++; $display("FAIL wrap_count_zero: got %h expected 0000", msg_count); end
      q.delete();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_pad_full();
      test_stall();
      test_single();
      test_async_reset();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/block_packer.md
Name: block_packer

Overview:
- Upstream of crypto_accelerator_top. Packs a byte stream with an end-of-message flag into BLOCK_WIDTH-bit blocks and drives the accelerator's data_in/data_in_valid/data_in_ready stream.
- Applies PKCS#7-style padding to the final block of each message.
- Counts the messages it has completed.

Parameters:
- BLOCK_WIDTH, 32: output block width. Must be a multiple of 8, with BLOCK_WIDTH/8 in 2..255.
- PAD_FULL_BLOCK, 1: if 1, a message whose length is an exact multiple of the block size gets an extra all-pad block. If 0, its last data block is marked last and no pad block is added.
- MSG_COUNT_WIDTH, 16: width of the completed-message counter.

Ports:
- clk  input  1  clock. The whole block is in this single clock domain.
- rst  input  1  asynchronous, active-high reset.
- byte_in  input  8  input byte.
- byte_in_valid  input  1  byte_in is valid.
- byte_in_last  input  1  byte_in is the final byte of the message. Qualified by byte_in_valid.
- byte_in_ready  output  1  block can accept a byte this cycle.
- data_out  output  BLOCK_WIDTH  packed block. The first byte of a block is in the MSBs.
- data_out_valid  output  1  data_out is valid.
- data_out_last  output  1  data_out is the final block of the message.
- data_out_ready  input  1  downstream accepts data_out.
- busy  output  1  a message is partially accepted, or a block is pending output.
- msg_count  output  MSG_COUNT_WIDTH  number of messages whose last block has been accepted downstream. Wraps modulo 2^MSG_COUNT_WIDTH.

Behaviour:
- Definitions:
  - NB = BLOCK_WIDTH/8.
  - A byte is accepted when byte_in_valid && byte_in_ready.
  - A block is accepted when data_out_valid && data_out_ready.
- Storage:
  - accumulator acc with byte index idx (0..NB-1).
  - one output register (data_out, data_out_valid, data_out_last).
  - state: FILL or PAD.
- Reset (async, while rst=1):
  - state=FILL, idx=0, acc=0.
  - data_out=0, data_out_valid=0, data_out_last=0, msg_count=0, busy=0.
  - Any in-flight partial message is discarded.
- Output register:
  - oreg_free = !data_out_valid || data_out_ready.
  - data_out/data_out_last hold stable while data_out_valid && !data_out_ready.
- FILL state:
  - byte_in_ready = 1, except 0 when the incoming byte would close a block (idx==NB-1, or byte_in_last=1) and oreg_free=0.
  - Accepted byte, not closing: written into byte lane idx (bits [BLOCK_WIDTH-1-8*idx -: 8]); idx increments.
  - Closing with idx==NB-1 and byte_in_last=0: {acc, byte} loads the output register with last=0; idx returns to 0.
  - Closing with byte_in_last=1 and idx<NB-1:
    - Remaining p = NB-1-idx lanes are filled with the value p.
    - Output register loads with last=1; idx returns to 0.
  - Closing with byte_in_last=1 and idx==NB-1:
    - PAD_FULL_BLOCK=1: output register loads the data block with last=0; go to PAD.
    - PAD_FULL_BLOCK=0: output register loads the data block with last=1; no PAD.
- PAD state:
  - byte_in_ready=0.
  - When oreg_free: output register loads NB copies of byte value NB (0x04040404 for 32-bit), last=1; return to FILL.
- Latency:
  - A block becomes data_out_valid on the cycle after the byte that closes it is accepted.
  - The pad block appears at the earliest cycle after the preceding block is accepted (back-to-back if data_out_ready stays high).
- Throughput: one byte per cycle sustained with data_out_ready=1. A load and an unload of the output register may occur in the same cycle.
- msg_count increments on each accepted block with data_out_last=1.
- busy = (idx!=0) || (state==PAD) || data_out_valid.
- A 1-byte message pads to NB-1 lanes of value NB-1 (e.g. 0xAB030303 for 32-bit).
- byte_in_last with byte_in_valid=0 is ignored.

Test Plan:
- Bytes 11,22,33,44,55 (last on 55), data_out_ready=1 -> 0x11223344 last=0, then 0x55030303 last=1; msg_count=1.
- Bytes AA,BB,CC,DD (last on DD), PAD_FULL_BLOCK=1 -> 0xAABBCCDD last=0, next cycle 0x04040404 last=1; byte_in_ready=0 during PAD. Repeat with PAD_FULL_BLOCK=0 -> only 0xAABBCCDD last=1.
- Continuous 12 bytes 00..0B (last on 0B), data_out_ready held 0 for 10 cycles:
  - data_out holds 0x00010203 stable throughout the stall.
  - byte_in_ready drops at the 8th byte.
  - After release, blocks 0x04050607, 0x08090A0B, then 0x04040404 last=1, with no loss or duplication.
- Single byte 7E last -> 0x7E030303 last=1, latency 1 cycle. Then 2-byte message 01,02 -> 0x01020202 last=1; msg_count=2.
- Assert rst asynchronously after 2 bytes of a message, mid-stall with data_out_valid=1:
  - data_out_valid, busy and msg_count go to 0 immediately.
  - After release, bytes 10,20,30,40 last -> 0x10203040, then 0x04040404 (no stale bytes).
- 2^16 one-byte messages -> msg_count wraps to 0.
